// File: rtl/oisc8_pkg.sv
// Shared OISC8 definitions: bus port addresses and the fetch sequencer's state encoding.
package oisc8_pkg;

  typedef enum logic [7:0] {
    NONE  = 8'h00,
    BRPT0 = 8'hF0,
    BRPT1 = 8'hF1,
    BRZ   = 8'hF2
  } e_iaddr;

  typedef enum logic [7:0] {
    NULL_ = 8'h00
  } e_iaddr_src;

  typedef enum logic [1:0] {
    ISSUE  = 2'd0,
    FETCH  = 2'd1,
    BUBBLE = 2'd2,
    HALT   = 2'd3
  } e_fetch_state;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/oisc8_fetch_if.sv
// Fetch sequencer connections: ROM read port, instruction bus, data bus snoop and halt.
interface oisc8_fetch_if
  import oisc8_pkg::*;
#(
  parameter int ASIZE = 8,
  parameter int PC_W  = 16
);

  // ROM protocol: rom_en high requests the word at rom_addr; rom_data returns it
  // on the following cycle. There is no back-pressure, the ROM accepts every request.
  logic               halt;
  logic [7:0]         bus_data;
  logic [2*ASIZE-1:0] rom_data;
  logic               rom_en;
  logic [PC_W-1:0]    rom_addr;
  logic [2*ASIZE-1:0] instr;
  logic [PC_W-1:0]    pc_dbg;
  e_fetch_state       state_dbg;

  modport master (
    input  halt, bus_data, rom_data,
    output rom_en, rom_addr, instr, pc_dbg, state_dbg
  );

  modport slave (
    output halt, bus_data, rom_data,
    input  rom_en, rom_addr, instr, pc_dbg, state_dbg
  );

endinterface

// File: rtl/oisc8_fetch.sv
// Instruction fetch sequencer: owns the PC, drives the program ROM and resolves
// BRPT0/BRPT1/BRZ by snooping the data bus. A taken branch costs one bubble cycle.
module oisc8_fetch
  import oisc8_pkg::*;
#(
  parameter int ASIZE = 8,
  parameter int PC_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  oisc8_fetch_if.master fif
);

  e_fetch_state    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     brpt_q, brpt_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [PC_W-1:0] pc_dbg_q, pc_dbg_d;

  logic [2*ASIZE-1:0] instr;
  logic [ASIZE-1:0]   dst;
  logic [ASIZE-1:0]   src;
  logic               brz_taken;
  logic               rom_en;
  logic [PC_W-1:0]    rom_addr;

  // A halted FETCH suppresses its instruction, so nothing downstream decodes it.
  assign instr     = (state_q == FETCH && !fif.halt) ? fif.rom_data : NOP_INSTR;
  assign dst       = instr[2*ASIZE-1:ASIZE];
  assign src       = instr[ASIZE-1:0];
  assign brz_taken = (dst == ASIZE'(BRZ)) && (src != ASIZE'(NULL_)) && (fif.bus_data == 8'h00);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    brpt_d   = brpt_q;
    tgt_d    = tgt_q;
    rom_en   = 1'b0;
    rom_addr = pc_q;
    case (state_q)
      ISSUE: begin
        rom_en = 1'b1;
        if (!fif.halt) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      FETCH: begin
        rom_en = 1'b1;
        pc_d   = pc_q + PC_W'(1);
        if (fif.halt) begin
          // pc already points past the suppressed word; step back so it is replayed.
          pc_d    = pc_q - PC_W'(1);
          state_d = HALT;
        end else if (dst == ASIZE'(BRPT0)) begin
          brpt_d[7:0] = fif.bus_data;
        end else if (dst == ASIZE'(BRPT1)) begin
          brpt_d[15:8] = fif.bus_data;
        end else if (brz_taken) begin
          tgt_d   = PC_W'(brpt_q);
          state_d = BUBBLE;
        end
      end
      BUBBLE: begin
        rom_en   = 1'b1;
        rom_addr = tgt_q;
        if (fif.halt) begin
          pc_d    = tgt_q;
          state_d = HALT;
        end else begin
          pc_d    = tgt_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      HALT: begin
        if (!fif.halt) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
    pc_dbg_d = rom_en ? rom_addr : pc_dbg_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ISSUE;
      pc_q     <= '0;
      brpt_q   <= '0;
      tgt_q    <= '0;
      pc_dbg_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      brpt_q   <= brpt_d;
      tgt_q    <= tgt_d;
      pc_dbg_q <= pc_dbg_d;
    end
  end

  // ISSUE is the reset state, so the read enable is masked while reset is held.
  assign fif.rom_en    = rom_en & rst;
  assign fif.rom_addr  = rom_addr;
  assign fif.instr     = instr;
  assign fif.pc_dbg    = pc_dbg_q;
  assign fif.state_dbg = state_q;

endmodule

// File: tb/tb_oisc8_fetch.sv
// Bench for oisc8_fetch: directed program scenarios with literal expectations, then
// randomized programs/halt/bus traffic checked every cycle against a behavioural model.
module tb_oisc8_fetch;
  import oisc8_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  oisc8_fetch_if #(.ASIZE(8), .PC_W(16)) fif ();

  oisc8_fetch #(.ASIZE(8), .PC_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  // ---------------- environment: ROM and data bus ----------------
  logic [15:0] rom [0:65535];
  logic [7:0]  src_val [0:255];
  bit          dir_mode = 1'b1;
  logic [7:0]  rnd_bus  = 8'h00;

  always @(posedge clk) if (fif.rom_en) fif.rom_data <= rom[fif.rom_addr];

  // Directed runs: the selected source port drives the bus, as in the real core.
  assign fif.bus_data = dir_mode ? src_val[fif.instr[7:0]] : rnd_bus;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_addr: address of the next instruction to be presented on instr.
  // m_wait: that address must still be read from the ROM before it appears.
  // m_branch: the pending read is a branch target. m_frozen: waiting for halt release.
  logic [15:0] m_addr, m_brpt, m_last;
  bit          m_wait, m_branch, m_frozen;

  task automatic model_cycle();
    logic [15:0] e_instr, e_addr, w;
    bit          e_en;
    if (!rst) begin
      chk("rst_instr", 32'(fif.instr), 32'h0);
      chk("rst_rom_en", 32'(fif.rom_en), 32'h0);
      chk("rst_rom_addr", 32'(fif.rom_addr), 32'h0);
      chk("rst_pc_dbg", 32'(fif.pc_dbg), 32'h0);
      m_addr = 16'h0; m_brpt = 16'h0; m_last = 16'h0;
      m_wait = 1'b1; m_branch = 1'b0; m_frozen = 1'b0;
    end else begin
      e_instr = 16'h0;
      e_en    = 1'b1;
      e_addr  = m_addr;
      if (m_frozen) e_en = 1'b0;
      else if (!m_wait) begin
        e_addr = m_addr + 16'd1;
        if (!fif.halt) e_instr = rom[m_addr];
      end
      chk("instr", 32'(fif.instr), 32'(e_instr));
      chk("rom_en", 32'(fif.rom_en), 32'(e_en));
      if (e_en) chk("rom_addr", 32'(fif.rom_addr), 32'(e_addr));
      chk("pc_dbg", 32'(fif.pc_dbg), 32'(m_last));
      if (e_en) m_last = e_addr;
      if (m_frozen) begin
        if (!fif.halt) begin m_frozen = 1'b0; m_wait = 1'b1; m_branch = 1'b0; end
      end else if (m_wait) begin
        if (fif.halt && m_branch) begin m_frozen = 1'b1; m_branch = 1'b0; end
        else if (!fif.halt) begin m_wait = 1'b0; m_branch = 1'b0; end
      end else if (fif.halt) begin
        m_frozen = 1'b1;
      end else begin
        w = rom[m_addr];
        if (w[15:8] == BRPT0) m_brpt[7:0] = fif.bus_data;
        if (w[15:8] == BRPT1) m_brpt[15:8] = fif.bus_data;
        if (w[15:8] == BRZ && w[7:0] != NULL_ && fif.bus_data == 8'h00) begin
          m_addr = m_brpt; m_wait = 1'b1; m_branch = 1'b1;
        end else begin
          m_addr = m_addr + 16'd1;
        end
      end
    end
  endtask

  always @(negedge clk) model_cycle();

  // ---------------- driver tasks ----------------
  task automatic adv(input bit h);
    @(posedge clk);
    #2;
    fif.halt = h;
    @(negedge clk);
  endtask

  task automatic prog_base();
    #2;
    rst      = 1'b0;
    dir_mode = 1'b1;
    fif.halt = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i]     = {8'h40, 8'(i)};
      src_val[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
  endtask

  // Leaves the bench at the check point of cycle 0 (the first ISSUE).
  task automatic release_rst();
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_branch(input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] brz_src, input logic [7:0] bz_val);
    rom[3] = {BRPT0, 8'h21};
    rom[4] = {BRPT1, 8'h22};
    rom[5] = {BRZ, brz_src};
    src_val[8'h21]  = lo;
    src_val[8'h22]  = hi;
    src_val[brz_src] = bz_val;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] seq [0:3];
    fif.halt = 1'b0;

    // Streaming after reset release.
    prog_base();
    seq[0] = 16'h0102; seq[1] = 16'h0304; seq[2] = 16'h0506; seq[3] = 16'h0708;
    for (int i = 0; i < 4; i++) rom[i] = seq[i];
    chk("reset_state", 32'(fif.state_dbg), 32'(ISSUE));
    release_rst();
    chk("s1_c0_instr", 32'(fif.instr), 32'h0);
    for (int k = 0; k < 4; k++) begin
      adv(1'b0);
      chk("s1_instr", 32'(fif.instr), 32'(seq[k]));
      chk("s1_pc_dbg", 32'(fif.pc_dbg), 32'(k));
    end

    // Taken branch to 0x1234.
    prog_base();
    set_branch(8'h34, 8'h12, 8'h23, 8'h00);
    rom[16'h1234] = 16'hBEEF;
    release_rst();
    repeat (7) adv(1'b0);
    chk("s2_bubble", 32'(fif.instr), 32'h0);
    adv(1'b0);
    chk("s2_target", 32'(fif.instr), 32'hBEEF);
    chk("s2_pc_dbg", 32'(fif.pc_dbg), 32'h1234);

    // Not taken: non-zero bus.
    prog_base();
    set_branch(8'h34, 8'h12, 8'h23, 8'h07);
    release_rst();
    repeat (7) adv(1'b0);
    chk("s3a_no_bubble", 32'(fif.instr), 32'h4006);

    // Not taken: NULL_ source.
    prog_base();
    set_branch(8'h34, 8'h12, 8'h00, 8'h00);
    release_rst();
    repeat (7) adv(1'b0);
    chk("s3b_null_src", 32'(fif.instr), 32'h4006);

    // Halt three cycles while rom[9] is presented.
    prog_base();
    rom[9] = {BRPT0, 8'h24};
    src_val[8'h24] = 8'h99;
    release_rst();
    repeat (9) adv(1'b0);
    adv(1'b1);
    chk("s4_suppressed", 32'(fif.instr), 32'h0);
    adv(1'b1);
    chk("s4_halt_rom_en", 32'(fif.rom_en), 32'h0);
    adv(1'b1);
    adv(1'b0);
    chk("s4_release_instr", 32'(fif.instr), 32'h0);
    adv(1'b0);
    chk("s4_issue_addr", 32'(fif.rom_addr), 32'h9);
    adv(1'b0);
    chk("s4_replay", 32'(fif.instr), 32'hF024);
    chk("s4_replay_pc", 32'(fif.pc_dbg), 32'h9);
    adv(1'b0);
    chk("s4_next", 32'(fif.instr), 32'h400A);

    // Halt during the bubble of a branch to 0x0040.
    prog_base();
    set_branch(8'h40, 8'h00, 8'h23, 8'h00);
    rom[16'h0040] = 16'h4142;
    release_rst();
    repeat (6) adv(1'b0);
    adv(1'b1);
    adv(1'b0);
    adv(1'b0);
    chk("s5_issue_tgt", 32'(fif.rom_addr), 32'h40);
    adv(1'b0);
    chk("s5_target", 32'(fif.instr), 32'h4142);
    chk("s5_pc_dbg", 32'(fif.pc_dbg), 32'h40);

    // Branch to 0xFFFF wraps to 0x0000.
    prog_base();
    set_branch(8'hFF, 8'hFF, 8'h23, 8'h00);
    rom[16'hFFFF] = 16'h5A5A;
    release_rst();
    repeat (8) adv(1'b0);
    chk("s6_top", 32'(fif.instr), 32'h5A5A);
    adv(1'b0);
    chk("s6_wrap", 32'(fif.instr), 32'h4000);
    chk("s6_wrap_pc", 32'(fif.pc_dbg), 32'h0);

    // Reset asserted in the bubble cycle.
    prog_base();
    set_branch(8'h34, 8'h12, 8'h23, 8'h00);
    release_rst();
    repeat (6) adv(1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("s7_rst_instr", 32'(fif.instr), 32'h0);
    chk("s7_rst_addr", 32'(fif.rom_addr), 32'h0);
    chk("s7_rst_en", 32'(fif.rom_en), 32'h0);
    release_rst();
    adv(1'b0);
    chk("s7_restart", 32'(fif.instr), 32'h4000);

    // Randomized programs, halts, bus values and occasional resets.
    #2;
    rst = 1'b0;
    dir_mode = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] d, s;
      case ($urandom_range(0, 7))
        0: d = BRPT0;
        1: d = BRPT1;
        2, 3: d = BRZ;
        default: d = 8'($urandom_range(1, 8'hEF));
      endcase
      s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rom[i] = {d, s};
    end
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      fif.halt = ($urandom_range(0, 7) == 0);
      rnd_bus  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      rst      = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
